// File: rtl/rc5_decryption.sv
// RC5-32/12 block decryptor. Iterative: one inverse round per clock,
// with valid/ready handshakes on the ciphertext input and plaintext output.
// The expanded key table is a fixed ROM shared with the encryption core.
module rc5_decryption #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_ROUNDS = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*WORD_SIZE-1:0] d_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WORD_SIZE-1:0] d_out,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t                 state;
    logic [WORD_SIZE-1:0]   a, b;
    logic [3:0]             round;
    logic [WORD_SIZE-1:0]   b_new, a_new;

    // Expanded key ROM S[0..25]
    function automatic logic [WORD_SIZE-1:0] key(input logic [4:0] idx);
        case (idx)
            5'd0:    key = 32'h00000000;
            5'd1:    key = 32'h00000000;
            5'd2:    key = 32'h46F8E8C5;
            5'd3:    key = 32'h460C6085;
            5'd4:    key = 32'h70F83B8A;
            5'd5:    key = 32'h284B8303;
            5'd6:    key = 32'h513E1454;
            5'd7:    key = 32'hF621ED22;
            5'd8:    key = 32'h3125065D;
            5'd9:    key = 32'h11A83A5D;
            5'd10:   key = 32'hD427686B;
            5'd11:   key = 32'h713AD82D;
            5'd12:   key = 32'h4B792F99;
            5'd13:   key = 32'h2799A4DD;
            5'd14:   key = 32'hA7901C49;
            5'd15:   key = 32'hDEDE871A;
            5'd16:   key = 32'h36C03196;
            5'd17:   key = 32'hA7EFC249;
            5'd18:   key = 32'h61A78BB8;
            5'd19:   key = 32'h3B0A1D2B;
            5'd20:   key = 32'h4DBFCA76;
            5'd21:   key = 32'hAE162167;
            5'd22:   key = 32'h30D76B0A;
            5'd23:   key = 32'h43192304;
            5'd24:   key = 32'hF6CC1431;
            5'd25:   key = 32'h65046380;
            default: key = '0;
        endcase
    endfunction

    // Rotate right via a doubled word so an amount of 0 never becomes a
    // full-width shift.
    function automatic logic [WORD_SIZE-1:0] ror(input logic [WORD_SIZE-1:0] x,
                                                 input logic [4:0]           n);
        logic [2*WORD_SIZE-1:0] t;
        t = {x, x} >> n;
        return t[WORD_SIZE-1:0];
    endfunction

    // One inverse round: undo B first (it was written last), then A using new B
    always_comb begin
        b_new = ror(b - key({round, 1'b1}), a[4:0]) ^ a;
        a_new = ror(a - key({round, 1'b0}), b_new[4:0]) ^ b_new;
    end

    assign busy = (state != IDLE);

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d_out     <= '0;
            a         <= '0;
            b         <= '0;
            round     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a        <= d_in[2*WORD_SIZE-1:WORD_SIZE];
                        b        <= d_in[WORD_SIZE-1:0];
                        round    <= LAST_ROUND;
                        in_ready <= 1'b0;
                        state    <= ROUND;
                    end
                end
                ROUND: begin
                    a     <= a_new;
                    b     <= b_new;
                    round <= round - 4'd1;
                    if (round == 4'd1)
                        state <= FINAL;
                end
                FINAL: begin
                    d_out     <= {a - key(5'd0), b - key(5'd1)};
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    d_out     <= '0;
                    a         <= '0;
                    b         <= '0;
                    round     <= '0;
                end
            endcase
        end
    end

endmodule
